// File: rtl/fc_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_sequencer_if
// Purpose  : Control, pixel/weight read and output-write bus of one FC layer.
// Revision : 1.0  initial release
// ============================================================================
interface fc_layer_sequencer_if #(
   parameter int N_IN   = 784,
   parameter int N_OUT  = 16,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
);
   localparam int PX_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   logic              start;
   logic              busy;
   logic              done;
   logic [PX_W-1:0]   px_addr;
   logic [DATA_W-1:0] px_data;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic              out_we;
   logic [OUT_W-1:0]  out_addr;
   logic [DATA_W-1:0] out_data;

   // The sequencer is the master: it issues addresses and write strobes.
   modport master (
      input  start, px_data, w_data,
      output busy, done, px_addr, w_addr, out_we, out_addr, out_data
   );

   modport slave (
      output start, px_data, w_data,
      input  busy, done, px_addr, w_addr, out_we, out_addr, out_data
   );
endinterface
`default_nettype wire

// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_sequencer
// Purpose  : Evaluates one fully-connected layer with a single shared MAC,
//            Q-format signed arithmetic and ReLU on every neuron result.
// Revision : 1.0  initial release
// ============================================================================
module fc_layer_sequencer #(
   parameter int N_IN   = 784,
   parameter int N_OUT  = 16,
   parameter int DATA_W = 32,
   parameter int FRAC   = 16,
   parameter int ADDR_W = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fc_layer_sequencer_if.master bus
);
   localparam int PX_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [PX_W-1:0]  c_I_LAST = PX_W'(N_IN - 1);
   localparam logic [OUT_W-1:0] c_J_LAST = OUT_W'(N_OUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_DRAIN = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                   r_state,    w_state_nxt;
   logic [PX_W-1:0]          r_i,        w_i_nxt;
   logic [OUT_W-1:0]         r_j,        w_j_nxt;
   logic [ADDR_W-1:0]        r_w_addr,   w_w_addr_nxt;
   logic signed [DATA_W-1:0] r_acc,      w_acc_nxt;
   logic                     r_vld,      w_vld_nxt;
   logic                     r_busy,     w_busy_nxt;
   logic                     r_done,     w_done_nxt;
   logic                     r_out_we,   w_out_we_nxt;
   logic [OUT_W-1:0]         r_out_addr, w_out_addr_nxt;
   logic [DATA_W-1:0]        r_out_data, w_out_data_nxt;

   logic signed [2*DATA_W-1:0] w_px_ext;
   logic signed [2*DATA_W-1:0] w_wt_ext;
   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [DATA_W-1:0]   w_term;
   logic signed [DATA_W-1:0]   w_acc_sum;

   // Full-width signed product, rescaled by FRAC, then wrapped to DATA_W.
   assign w_px_ext  = {{DATA_W{bus.px_data[DATA_W-1]}}, bus.px_data};
   assign w_wt_ext  = {{DATA_W{bus.w_data[DATA_W-1]}},  bus.w_data};
   assign w_prod    = w_px_ext * w_wt_ext;
   assign w_term    = DATA_W'(w_prod >>> FRAC);
   assign w_acc_sum = r_vld ? (r_acc + w_term) : r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_i        <= '0;
         r_j        <= '0;
         r_w_addr   <= '0;
         r_acc      <= '0;
         r_vld      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_out_we   <= 1'b0;
         r_out_addr <= '0;
         r_out_data <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_i        <= w_i_nxt;
         r_j        <= w_j_nxt;
         r_w_addr   <= w_w_addr_nxt;
         r_acc      <= w_acc_nxt;
         r_vld      <= w_vld_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_out_we   <= w_out_we_nxt;
         r_out_addr <= w_out_addr_nxt;
         r_out_data <= w_out_data_nxt;
      end
   end

   // Outputs are registered one step ahead so they line up with the state.
   always_comb begin
      w_state_nxt    = r_state;
      w_i_nxt        = r_i;
      w_j_nxt        = r_j;
      w_w_addr_nxt   = r_w_addr;
      w_acc_nxt      = w_acc_sum;
      w_vld_nxt      = (r_state == S_ISSUE);
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_out_we_nxt   = 1'b0;
      w_out_addr_nxt = r_out_addr;
      w_out_data_nxt = r_out_data;

      case (r_state)
         S_IDLE: begin
            w_acc_nxt = '0;
            if (bus.start) begin
               w_state_nxt  = S_ISSUE;
               w_i_nxt      = '0;
               w_j_nxt      = '0;
               w_w_addr_nxt = '0;
               w_busy_nxt   = 1'b1;
            end
         end
         S_ISSUE: begin
            if (r_i == c_I_LAST) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_i_nxt      = r_i + PX_W'(1);
               w_w_addr_nxt = r_w_addr + ADDR_W'(1);
            end
         end
         S_DRAIN: begin
            w_state_nxt    = S_WRITE;
            w_out_we_nxt   = 1'b1;
            w_out_addr_nxt = r_j;
            w_out_data_nxt = w_acc_sum[DATA_W-1] ? '0 : w_acc_sum;
         end
         S_WRITE: begin
            w_acc_nxt = '0;
            w_i_nxt   = '0;
            if (r_j == c_J_LAST) begin
               w_state_nxt  = S_DONE;
               w_w_addr_nxt = '0;
               w_busy_nxt   = 1'b0;
               w_done_nxt   = 1'b1;
            end else begin
               w_state_nxt  = S_ISSUE;
               w_j_nxt      = r_j + OUT_W'(1);
               w_w_addr_nxt = r_w_addr + ADDR_W'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.px_addr  = r_i;
   assign bus.w_addr   = r_w_addr;
   assign bus.out_we   = r_out_we;
   assign bus.out_addr = r_out_addr;
   assign bus.out_data = r_out_data;
endmodule
`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_layer_sequencer
// Purpose  : Directed vector table plus corner sequences for fc_layer_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_fc_layer_sequencer;
   localparam int N_IN    = 4;
   localparam int N_OUT   = 3;
   localparam int DATA_W  = 32;
   localparam int FRAC    = 16;
   localparam int ADDR_W  = 14;
   localparam int NEU_CYC = N_IN + 2;
   localparam int RUN_CYC = N_OUT * NEU_CYC;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fc_layer_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
   fc_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC(FRAC), .ADDR_W(ADDR_W))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   fc_layer_sequencer_if #(.N_IN(1), .N_OUT(N_OUT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();
   fc_layer_sequencer #(.N_IN(1), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC(FRAC), .ADDR_W(ADDR_W))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   // Synchronous-read memory models, one cycle latency.
   logic [DATA_W-1:0] pix  [0:N_IN-1];
   logic [DATA_W-1:0] wts  [0:15];
   logic [DATA_W-1:0] pix1 [0:1];
   logic [DATA_W-1:0] wts1 [0:3];
   always @(posedge clk) begin
      bus.px_data  <= pix[bus.px_addr];
      bus.w_data   <= wts[bus.w_addr[3:0]];
      bus1.px_data <= pix1[bus1.px_addr];
      bus1.w_data  <= wts1[bus1.w_addr[1:0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int                wr_n, done_n, b2b_n, done_cyc;
   logic              prev_we = 1'b0;
   logic [DATA_W-1:0] wr_data [0:7];
   logic [1:0]        wr_addr [0:7];
   always @(negedge clk) begin
      if (bus.out_we) begin
         if (wr_n < 8) begin
            wr_data[wr_n] = bus.out_data;
            wr_addr[wr_n] = bus.out_addr;
         end
         wr_n = wr_n + 1;
         if (prev_we) b2b_n = b2b_n + 1;
      end
      if (bus.done) begin
         done_n   = done_n + 1;
         done_cyc = cyc;
      end
      prev_we = bus.out_we;
   end

   int n_pass = 0;
   int n_chk  = 0;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [N_IN-1:0][DATA_W-1:0]  px;   // index 0 is rightmost
      logic [N_OUT-1:0][DATA_W-1:0] w;    // one weight per neuron, all inputs
      logic [N_OUT-1:0][DATA_W-1:0] e;    // expected ReLU outputs
   } vec_t;
   vec_t vecs [5];

   task automatic load(input vec_t v);
      for (int i = 0; i < N_IN; i++) pix[i] = v.px[i];
      for (int j = 0; j < N_OUT; j++)
         for (int i = 0; i < N_IN; i++) wts[j*N_IN+i] = v.w[j];
   endtask

   task automatic clr_mon();
      @(posedge clk); #1;
      wr_n = 0; done_n = 0; b2b_n = 0; done_cyc = -1;
   endtask

   task automatic kick(output int k);
      @(negedge clk); bus.start = 1'b1;
      @(posedge clk); #1; k = cyc; bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < budget && !ok; t++) begin
         @(posedge clk); #1;
         if (done_n > 0) ok = 1'b1;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int k; bit ok;
      load(v);
      clr_mon();
      kick(k);
      wait_done(60, ok);
      repeat (2) @(posedge clk);
      #1;
      check({tag, " done seen"}, 64'(ok), 64'd1);
      check({tag, " done latency"}, 64'(done_cyc - k), 64'(RUN_CYC));
      check({tag, " write count"}, 64'(wr_n), 64'(N_OUT));
      check({tag, " back-to-back we"}, 64'(b2b_n), 64'd0);
      for (int j = 0; j < N_OUT; j++) begin
         check($sformatf("%s j%0d addr", tag, j), 64'(wr_addr[j]), 64'(j));
         check($sformatf("%s j%0d data", tag, j), 64'(wr_data[j]), 64'(v.e[j]));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   k, d1, cnt, j, pos, n1, d;
      bit   ok, seen;
      logic busy_seen, we_seen;
      logic [DATA_W-1:0] got1 [0:3];

      vecs[0] = '{px: {4{32'h0001_0000}},
                  w:  {32'h0002_0000, 32'hFFFF_C000, 32'h0000_8000},
                  e:  {32'h0008_0000, 32'h0000_0000, 32'h0002_0000}};
      vecs[1] = '{px: {4{32'h7FFF_0000}},
                  w:  {32'h0000_8000, 32'h0000_0001, 32'h0002_0000},
                  e:  {32'h0000_0000, 32'h0001_FFFC, 32'h0000_0000}};
      vecs[2] = '{px: {4{32'h0003_0000}},
                  w:  {32'h0001_8000, 32'hFFFF_0000, 32'h0000_4000},
                  e:  {32'h0012_0000, 32'h0000_0000, 32'h0003_0000}};
      vecs[3] = '{px: {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
                  w:  {32'h0000_8000, 32'hFFFF_8000, 32'h0001_0000},
                  e:  {32'h0005_0000, 32'h0000_0000, 32'h000A_0000}};
      vecs[4] = '{px: {32'h0010_0000, 32'h0010_0000, 32'h0010_0000, 32'hFFFF_FFFD},
                  w:  {32'hFFFF_0000, 32'h0001_0000, 32'h0000_8000},
                  e:  {32'h0000_0000, 32'h002F_FFFD, 32'h0017_FFFE}};

      for (int i = 0; i < 16; i++) wts[i] = '0;
      pix1[0] = 32'h0001_0000; pix1[1] = '0;
      wts1[0] = 32'h0000_8000; wts1[1] = 32'hFFFF_C000; wts1[2] = 32'h0002_0000; wts1[3] = '0;
      wr_n = 0; done_n = 0; b2b_n = 0; done_cyc = -1;

      // Reset values
      rst_n = 1'b0; bus.start = 1'b0; bus1.start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst done", 64'(bus.done), 64'd0);
      check("rst out_we", 64'(bus.out_we), 64'd0);
      check("rst px_addr", 64'(bus.px_addr), 64'd0);
      check("rst w_addr", 64'(bus.w_addr), 64'd0);
      check("rst out_addr", 64'(bus.out_addr), 64'd0);
      check("rst out_data", 64'(bus.out_data), 64'd0);
      rst_n = 1'b1;
      busy_seen = 1'b0; we_seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         busy_seen |= bus.busy;
         we_seen   |= bus.out_we;
      end
      check("idle busy", 64'(busy_seen), 64'd0);
      check("idle out_we", 64'(we_seen), 64'd0);

      // Vector table
      for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

      // Address trace on the golden vector
      load(vecs[0]);
      clr_mon();
      kick(k);
      for (int r = 0; r < RUN_CYC; r++) begin
         @(negedge clk);
         j = r / NEU_CYC; pos = r % NEU_CYC;
         check($sformatf("trace r%0d busy", r), 64'(bus.busy), 64'd1);
         if (pos < N_IN) begin
            check($sformatf("trace r%0d px_addr", r), 64'(bus.px_addr), 64'(pos));
            check($sformatf("trace r%0d w_addr", r), 64'(bus.w_addr), 64'(j*N_IN + pos));
         end
      end
      @(negedge clk);
      check("trace done", 64'(bus.done), 64'd1);
      check("trace busy end", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check("trace done width", 64'(bus.done), 64'd0);
      for (int w = 0; w < N_OUT; w++)
         check($sformatf("trace out_addr %0d", w), 64'(wr_addr[w]), 64'(w));

      // start pulsed during ISSUE and during DONE
      clr_mon();
      kick(k);
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (30) @(negedge clk);
      check("ignored start done seen", 64'(seen), 64'd1);
      check("ignored start writes", 64'(wr_n), 64'(N_OUT));
      check("ignored start done count", 64'(done_n), 64'd1);
      check("ignored start busy", 64'(bus.busy), 64'd0);
      check("ignored start j2 data", 64'(wr_data[2]), 64'h0008_0000);

      // start held high: back-to-back runs with one IDLE cycle
      clr_mon();
      @(negedge clk);
      bus.start = 1'b1;
      seen = 1'b0; d1 = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         if (bus.done) begin seen = 1'b1; d1 = cyc; end
      end
      @(negedge clk);
      check("held idle busy", 64'(bus.busy), 64'd0);
      check("held idle done", 64'(bus.done), 64'd0);
      @(negedge clk);
      check("held rerun busy", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      seen = 1'b0; d = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         if (bus.done) begin seen = 1'b1; d = cyc; end
      end
      check("held second done seen", 64'(seen), 64'd1);
      check("held run spacing", 64'(d - d1), 64'(RUN_CYC + 2));
      repeat (3) @(negedge clk);
      check("held write count", 64'(wr_n), 64'(2*N_OUT));
      check("held done count", 64'(done_n), 64'd2);

      // Reset after the second write
      clr_mon();
      kick(k);
      cnt = 0;
      for (int t = 0; t < 40 && cnt < 2; t++) begin
         @(negedge clk);
         if (bus.out_we) cnt++;
      end
      check("midreset reached 2 writes", 64'(cnt), 64'd2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset busy", 64'(bus.busy), 64'd0);
      check("midreset out_we", 64'(bus.out_we), 64'd0);
      check("midreset px_addr", 64'(bus.px_addr), 64'd0);
      check("midreset w_addr", 64'(bus.w_addr), 64'd0);
      check("midreset out_data", 64'(bus.out_data), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("midreset writes", 64'(wr_n), 64'd2);
      check("midreset done count", 64'(done_n), 64'd0);
      run_vec(vecs[0], "post-reset");

      // N_IN = 1 instance
      @(negedge clk); bus1.start = 1'b1;
      @(posedge clk); #1; k = cyc; bus1.start = 1'b0;
      n1 = 0; d = -1;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (bus1.out_we) begin
            if (n1 < 4) got1[n1] = bus1.out_data;
            n1++;
         end
         if (bus1.done) d = cyc;
      end
      check("nin1 done latency", 64'(d - k), 64'(N_OUT * 3));
      check("nin1 write count", 64'(n1), 64'(N_OUT));
      check("nin1 j0 data", 64'(got1[0]), 64'h0000_8000);
      check("nin1 j1 data", 64'(got1[1]), 64'h0000_0000);
      check("nin1 j2 data", 64'(got1[2]), 64'h0002_0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
